// File: rtl/balance_disp_pkg.sv
// Shared definitions for the balance display sequencer.
//  - state_t        : display FSM states
//  - ACC_*          : account index constants (USD, BTC, ETH, XRP, LTC)
//  - NUM_ACCT/SEL_W : account count and select width
//  - cnt_w()        : bits needed to hold a counter value
//  - ROT_CNT_W/HOLD_CNT_W : counter widths for the default tick settings
package balance_disp_pkg;

    localparam int NUM_ACCT = 5;
    localparam int SEL_W    = $clog2(NUM_ACCT);

    localparam int ACC_USD = 0;
    localparam int ACC_BTC = 1;
    localparam int ACC_ETH = 2;
    localparam int ACC_XRP = 3;
    localparam int ACC_LTC = 4;

    localparam int DEF_ROTATE_TICKS = 5;
    localparam int DEF_HOLD_TICKS   = 3;

    // Bits needed to represent max_val (never less than one).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int ROT_CNT_W  = cnt_w(DEF_ROTATE_TICKS - 1);
    localparam int HOLD_CNT_W = cnt_w(DEF_HOLD_TICKS);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        MANUAL = 2'd1,
        ROTATE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Next account index, wrapping from the last account back to USD.
    function automatic logic [SEL_W-1:0] next_acct(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_ACCT - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/pend_prio_enc.sv
// Lowest-set-bit encoder for the pending-update vector.
//  pend : in  NUM_ACCT  pending bits, one per account
//  any  : out 1         at least one bit set
//  idx  : out SEL_W     index of the lowest set bit (0 when none)
module pend_prio_enc
    import balance_disp_pkg::*;
(
    input  logic [NUM_ACCT-1:0] pend,
    output logic                any,
    output logic [SEL_W-1:0]    idx
);

    always_comb begin
        any = |pend;
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_ACCT - 1; i >= 0; i--) begin
            if (pend[i]) idx = SEL_W'(i);
        end
    end

endmodule

// File: rtl/balance_display_ctrl.sv
// Balance display sequencer: chooses which account drives the shared
// seven-segment decoder and snapshots its balance so digits never tear.
//  clk, rst_n   : clock, asynchronous active-low reset
//  tick         : 1 Hz single-cycle pulse
//  step         : debounced single-cycle button pulse
//  auto_en      : 1 = timed auto-rotation, 0 = manual stepping
//  upd_vld      : per-account update strobe (balance valid same cycle)
//  bal_*        : current account balances
//  disp_sel     : displayed account index
//  disp_value   : snapshot feeding the decoder
//  disp_load    : pulses in the cycle disp_sel/disp_value change
//  hold_active  : high while a just-updated account is being held
module balance_display_ctrl
    import balance_disp_pkg::*;
#(
    parameter int BAL_W        = 32,
    parameter int ROTATE_TICKS = DEF_ROTATE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                step,
    input  logic                auto_en,
    input  logic [NUM_ACCT-1:0] upd_vld,
    input  logic [BAL_W-1:0]    bal_usd,
    input  logic [BAL_W-1:0]    bal_btc,
    input  logic [BAL_W-1:0]    bal_eth,
    input  logic [BAL_W-1:0]    bal_xrp,
    input  logic [BAL_W-1:0]    bal_ltc,
    output logic [SEL_W-1:0]    disp_sel,
    output logic [BAL_W-1:0]    disp_value,
    output logic                disp_load,
    output logic                hold_active
);

    localparam int ROT_W  = cnt_w(ROTATE_TICKS - 1);
    localparam int HOLD_W = cnt_w(HOLD_TICKS);
    localparam logic [ROT_W-1:0]  ROT_LAST = ROT_W'(ROTATE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t                      state, state_nxt;
    logic [NUM_ACCT-1:0]         pend;
    logic [ROT_W-1:0]            rot_cnt;
    logic [HOLD_W-1:0]           hold_cnt;
    logic                        pend_any;
    logic [SEL_W-1:0]            pend_idx;
    logic [NUM_ACCT-1:0][BAL_W-1:0] bal_arr;

    // Per-cycle actions decided by the FSM.
    logic do_init, enter_hold, adv, rot_clr, rot_inc, hold_dec;
    logic [SEL_W-1:0] sel_nxt;
    logic             load;

    assign bal_arr[ACC_USD] = bal_usd;
    assign bal_arr[ACC_BTC] = bal_btc;
    assign bal_arr[ACC_ETH] = bal_eth;
    assign bal_arr[ACC_XRP] = bal_xrp;
    assign bal_arr[ACC_LTC] = bal_ltc;

    pend_prio_enc u_prio (
        .pend (pend),
        .any  (pend_any),
        .idx  (pend_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    // Next state. Priority outside HOLD: pending hold > mode change > step/tick.
    // A mode change cycle leaves disp_sel alone, so step/tick there are not acted on.
    always_comb begin
        state_nxt  = state;
        do_init    = 1'b0;
        enter_hold = 1'b0;
        adv        = 1'b0;
        rot_clr    = 1'b0;
        rot_inc    = 1'b0;
        hold_dec   = 1'b0;
        unique case (state)
            INIT: begin
                do_init   = 1'b1;
                rot_clr   = 1'b1;
                state_nxt = auto_en ? ROTATE : MANUAL;
            end
            MANUAL, ROTATE: begin
                if (pend_any) begin
                    enter_hold = 1'b1;
                    state_nxt  = HOLD;
                end else if (auto_en != (state == ROTATE)) begin
                    rot_clr   = 1'b1;
                    state_nxt = auto_en ? ROTATE : MANUAL;
                end else if (state == MANUAL) begin
                    adv = step;
                end else if (step || (tick && rot_cnt == ROT_LAST)) begin
                    adv     = 1'b1;
                    rot_clr = 1'b1;
                end else if (tick) begin
                    rot_inc = 1'b1;
                end
            end
            HOLD: begin
                if (step || (tick && hold_cnt == HOLD_ONE)) begin
                    adv       = step;
                    rot_clr   = 1'b1;
                    state_nxt = auto_en ? ROTATE : MANUAL;
                end else if (tick) begin
                    hold_dec = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Outputs derived directly from state.
    always_comb begin
        hold_active = (state == HOLD);
    end

    // Selection and snapshot. A refresh of the shown account reloads in place.
    always_comb begin
        sel_nxt = disp_sel;
        if (do_init)         sel_nxt = SEL_W'(ACC_USD);
        else if (enter_hold) sel_nxt = pend_idx;
        else if (adv)        sel_nxt = next_acct(disp_sel);
        load = do_init | enter_hold | adv | upd_vld[disp_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_sel   <= '0;
            disp_value <= '0;
            disp_load  <= 1'b0;
        end else begin
            disp_sel  <= sel_nxt;
            disp_load <= load;
            if (load) disp_value <= bal_arr[sel_nxt];
        end
    end

    // Pending updates: the bit being serviced clears, but a new strobe on
    // the same bit in the same cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(enter_hold ? (NUM_ACCT'(1) << pend_idx) : '0)) | upd_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (rot_clr)      rot_cnt <= '0;
            else if (rot_inc) rot_cnt <= rot_cnt + 1'b1;

            if (enter_hold)    hold_cnt <= HOLD_W'(HOLD_TICKS);
            else if (hold_dec) hold_cnt <= hold_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_balance_display_ctrl.sv
module tb_balance_display_ctrl;

    localparam int ROT  = 5;
    localparam int HOLD = 3;
    localparam int M_INIT = 0, M_MAN = 1, M_ROT = 2, M_HOLD = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0, step = 1'b0, auto_en = 1'b0;
    logic [4:0]        upd_vld = '0;
    logic [4:0][31:0]  bal;
    logic [2:0]        disp_sel;
    logic [31:0]       disp_value;
    logic              disp_load, hold_active;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    balance_display_ctrl #(.BAL_W(32), .ROTATE_TICKS(ROT), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .step(step), .auto_en(auto_en),
        .upd_vld(upd_vld),
        .bal_usd(bal[0]), .bal_btc(bal[1]), .bal_eth(bal[2]), .bal_xrp(bal[3]), .bal_ltc(bal[4]),
        .disp_sel(disp_sel), .disp_value(disp_value), .disp_load(disp_load),
        .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    // Reference model: what the display should be showing, from the rules.
    typedef struct packed {
        int          mode;
        int          sel;
        logic [31:0] val;
        logic        load;
        logic [4:0]  pend;
        int          rcnt;
        int          hcnt;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_next(mdl_t c, logic tk, logic st, logic ae,
                                        logic [4:0] uv, logic [4:0][31:0] b);
        mdl_t n = c;
        int lo = -1;
        bit moved = 0;
        n.load = 1'b0;
        for (int i = 4; i >= 0; i--) if (c.pend[i]) lo = i;
        if (c.mode == M_INIT) begin
            n.sel = 0; moved = 1; n.rcnt = 0;
            n.mode = ae ? M_ROT : M_MAN;
        end else if (c.mode == M_HOLD) begin
            if (st || (tk && c.hcnt == 1)) begin
                n.mode = ae ? M_ROT : M_MAN;
                n.rcnt = 0;
                if (st) begin n.sel = (c.sel + 1) % 5; moved = 1; end
            end else if (tk) begin
                n.hcnt = c.hcnt - 1;
            end
        end else begin
            if (lo >= 0) begin
                n.mode = M_HOLD; n.sel = lo; n.hcnt = HOLD; n.pend[lo] = 1'b0; moved = 1;
            end else if (ae != (c.mode == M_ROT)) begin
                n.mode = ae ? M_ROT : M_MAN; n.rcnt = 0;
            end else if (st) begin
                n.sel = (c.sel + 1) % 5; moved = 1; n.rcnt = 0;
            end else if (tk && c.mode == M_ROT) begin
                if (c.rcnt + 1 == ROT) begin
                    n.sel = (c.sel + 1) % 5; moved = 1; n.rcnt = 0;
                end else begin
                    n.rcnt = c.rcnt + 1;
                end
            end
        end
        n.pend = n.pend | uv;
        if (moved || uv[c.sel]) begin
            n.val  = b[n.sel];
            n.load = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, tick, step, auto_en, upd_vld, bal);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc_n, act, exp);
        end
    endtask

    // One clock: advance, then compare the DUT against the model on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (rst_n) begin
            chk("mdl_sel",  32'(disp_sel),    32'(m.sel));
            chk("mdl_val",  disp_value,       m.val);
            chk("mdl_load", 32'(disp_load),   32'(m.load));
            chk("mdl_hold", 32'(hold_active), 32'(m.mode == M_HOLD));
        end
    endtask

    task automatic go(input logic tk, input logic st, input logic [4:0] uv);
        tick = tk; step = st; upd_vld = uv;
        cycle();
        tick = 1'b0; step = 1'b0; upd_vld = '0;
    endtask

    task automatic lit(input string nm, input int sel, input logic ha);
        chk({nm, "_sel"},  32'(disp_sel),    32'(sel));
        chk({nm, "_hold"}, 32'(hold_active), 32'(ha));
    endtask

    initial begin
        for (int i = 0; i < 5; i++) bal[i] = 32'(100 * (i + 1));
        bal[0] = 32'd1234;
        @(negedge clk); @(negedge clk);
        chk("rst_sel",  32'(disp_sel),  0);
        chk("rst_val",  disp_value,     0);
        chk("rst_load", 32'(disp_load), 0);
        chk("rst_hold", 32'(hold_active), 0);

        // 1: reset release in manual mode shows USD with one load pulse
        rst_n = 1'b1;
        cycle();
        chk("t1_val", disp_value, 32'd1234);
        chk("t1_load", 32'(disp_load), 1);
        lit("t1", 0, 1'b0);
        go(0, 0, 5'b0);
        chk("t1_load_end", 32'(disp_load), 0);

        // 4: two updates queue two holds, lowest index first
        go(0, 0, 5'b10100); lit("t4_pend", 0, 1'b0);
        go(0, 0, 5'b0);     lit("t4_h2", 2, 1'b1);
        chk("t4_h2_val", disp_value, 32'd300);
        go(1, 0, 5'b0);     lit("t4_h2_t1", 2, 1'b1);
        go(1, 0, 5'b0);     lit("t4_h2_t2", 2, 1'b1);
        go(1, 0, 5'b0);     lit("t4_h2_t3", 2, 1'b0);
        go(0, 0, 5'b0);     lit("t4_h4", 4, 1'b1);
        chk("t4_h4_val", disp_value, 32'd500);
        go(1, 0, 5'b0); go(1, 0, 5'b0);
        go(1, 0, 5'b0);     lit("t4_h4_end", 4, 1'b0);

        // 5: step inside a hold exits and advances; the new update holds afterwards
        go(0, 0, 5'b00100);
        go(0, 0, 5'b0);     lit("t5_h2", 2, 1'b1);
        go(0, 1, 5'b00001); lit("t5_exit", 3, 1'b0);
        go(0, 0, 5'b0);     lit("t5_h0", 0, 1'b1);
        go(0, 1, 5'b0);     lit("t5_out", 1, 1'b0);

        // 2: manual stepping wraps; ticks do nothing
        for (int k = 0; k < 6; k++) begin
            go(0, 1, 5'b0); lit("t2_step", (2 + k) % 5, 1'b0);
            chk("t2_load", 32'(disp_load), 1);
            go(1, 0, 5'b0); lit("t2_tick", (2 + k) % 5, 1'b0);
        end

        // 3: auto-rotation every ROT ticks; a step restarts the count
        auto_en = 1'b1;
        go(0, 0, 5'b0);     lit("t3_sw", 2, 1'b0);
        for (int k = 1; k < ROT; k++) begin go(1, 0, 5'b0); lit("t3_wait", 2, 1'b0); end
        go(1, 0, 5'b0);     lit("t3_rot", 3, 1'b0);
        go(1, 0, 5'b0); go(1, 0, 5'b0);
        go(1, 1, 5'b0);     lit("t3_step", 4, 1'b0);
        for (int k = 1; k < ROT; k++) begin go(1, 0, 5'b0); lit("t3_wait2", 4, 1'b0); end
        go(1, 0, 5'b0);     lit("t3_rot2", 0, 1'b0);

        // 6: reset mid-hold with another update pending
        go(0, 0, 5'b00010);
        go(0, 0, 5'b0);     lit("t6_h1", 1, 1'b1);
        go(0, 0, 5'b01000); lit("t6_pend", 1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sel",  32'(disp_sel),    0);
        chk("t6_rst_val",  disp_value,       0);
        chk("t6_rst_load", 32'(disp_load),   0);
        chk("t6_rst_hold", 32'(hold_active), 0);
        @(negedge clk);
        auto_en = 1'b0; bal[0] = 32'd777;
        rst_n = 1'b1;
        cycle();
        chk("t6_init_val", disp_value, 32'd777);
        lit("t6_init", 0, 1'b0);
        for (int k = 0; k < 3; k++) begin go(0, 0, 5'b0); lit("t6_idle", 0, 1'b0); end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick = ($urandom_range(0, 3) == 0);
            step = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 5; i++) begin
                upd_vld[i] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) bal[i] = $urandom;
            end
            if ($urandom_range(0, 99) == 0) begin
                auto_en = ~auto_en; tick = 1'b0; step = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
